stage3_pow2_approx: RTL and testbench
=====================================

// Module: stage3_pow2_approx
// PURPOSE
//  Base-2 antilog (pow2) approximation stage of the softmax datapath; inverse of stage1_log2_approx.
//  Takes a signed Q6.10 log-domain value and returns 2^x in Q6.10 (Mitchell: 2^(I+F) ~= 2^I*(1+F)).
//  2-stage pipeline with valid tracking, global enable stall, and two bypass lanes aligned to the result.
// PARAMETERS
//  DATA_W  16  total word width (signed fixed point)
//  FRAC_W  10  fractional bits; integer bits = DATA_W-FRAC_W
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       synchronous reset, active-high
//  en           in   1       pipeline enable; 0 = stall (all registers hold)
//  valid_in     in   1       in_0/in_1 valid this cycle
//  in_0         in   DATA_W  signed Q6.10 exponent x
//  in_1         in   DATA_W  side data, carried unmodified
//  valid_out    out  1       pow_out and bypasses valid
//  pow_out      out  DATA_W  2^x, Q6.10, always >= 0
//  in_0_bypass  out  DATA_W  in_0 delayed to align with pow_out
//  in_1_bypass  out  DATA_W  in_1 delayed to align with pow_out
// BEHAVIOUR
//  Reset: rst=1 at a rising edge clears every pipeline register; valid_out, pow_out,
//   in_0_bypass, in_1_bypass all 0 next cycle. rst has priority over en. Reset mid-stream drops in-flight data.
//  Stage A (edge 1, en=1): I = in_0>>>FRAC_W (arithmetic, floor, range -32..31);
//   M = {1'b1, in_0[FRAC_W-1:0]} (FRAC_W+1 bits, Q1.10 of 1+F); register I, M, in_0, in_1, valid_in.
//  Stage B (edge 2, en=1): barrel shift with saturation:
//   I >= 5            -> pow_out = 16'h7FFF (saturate; I=4 max = 2047<<4 = 32752 fits)
//   0 <= I <= 4       -> pow_out = M << I
//   -10 <= I <= -1    -> pow_out = M >> (-I), truncate toward 0
//   I <= -11          -> pow_out = 0
//   pow_out MSB is always 0.
//  Latency: exactly 2 enabled edges from sampling valid_in=1 to valid_out=1; throughput 1/cycle.
//  Valid chain shifts on every enabled edge (valid_in=0 propagates as bubble).
//  Data/bypass registers of a stage load only when en=1 and that stage's incoming valid=1;
//   otherwise they hold (outputs keep last valid result while valid_out=0).
//  en=0: no register changes, valid_out held; resuming en=1 continues exactly where stalled.
//  en and valid_in are independent; valid_in while en=0 is ignored (not captured).
//  Back-to-back valids with en toggling: no loss, no duplication, order preserved.
// TESTING
//  1. rst=1 one edge, en=0 -> all outputs 0; en=1 with valid_in=0 -> valid_out stays 0.
//  2. in_0=0x0000,0x0400,0xFC00,0x0200,0x1000 back-to-back -> pow_out 0x0400,0x0800,0x0200,0x0600,0x4000,
//     valid_out high 2 cycles after each input, in_0_bypass/in_1_bypass aligned.
//  3. Boundaries: 0x1400 -> 0x7FFF; 0x7FFF -> 0x7FFF; 0x13FF -> 0x7FF0; 0xD800 -> 0x0001; 0xD400 -> 0x0000; 0x8000 -> 0x0000.
//  4. Stall: issue 3 valids, drop en for 4 cycles mid-stream -> outputs/valid_out frozen, then 3 results in order.
//  5. Bubbles: valid_in pattern 1,0,1 -> valid_out 1,0,1 two cycles later; pow_out holds during the 0 cycle.
//  6. Reset mid-operation with 2 items in flight -> next cycle all outputs 0, no stale valid_out afterwards.

Source files
------------

// File: rtl/stage3_pow2_approx.sv
// stage3_pow2_approx: Mitchell base-2 antilog, 2^(I+F) ~= 2^I * (1+F), signed Q6.10 in and Q6.10 out.
// Two-stage pipeline with a global stall enable and two side lanes kept aligned with the result.
module stage3_pow2_approx #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] in_0,
  input  logic [DATA_W-1:0] in_1,
  output logic              valid_out,
  output logic [DATA_W-1:0] pow_out,
  output logic [DATA_W-1:0] in_0_bypass,
  output logic [DATA_W-1:0] in_1_bypass
);

  localparam int unsigned INT_W = DATA_W - FRAC_W;
  localparam int unsigned MAN_W = FRAC_W + 1;
  // Largest left shift of the (1+F) mantissa that still fits below the sign bit.
  localparam int          MAX_LSH = int'(DATA_W) - int'(MAN_W) - 1;
  // Beyond this right shift the mantissa is shifted out entirely.
  localparam int          MIN_RSH = -int'(FRAC_W);
  localparam logic [DATA_W-1:0] SAT_VAL = {1'b0, {(DATA_W-1){1'b1}}};

  // Stage A registers: split exponent plus side data
  logic                     r_a_valid;
  logic signed [INT_W-1:0]  r_a_int;
  logic [MAN_W-1:0]         r_a_man;
  logic [DATA_W-1:0]        r_a_in0;
  logic [DATA_W-1:0]        r_a_in1;

  // Stage B registers: result plus aligned side data
  logic                     r_b_valid;
  logic [DATA_W-1:0]        r_b_pow;
  logic [DATA_W-1:0]        r_b_in0;
  logic [DATA_W-1:0]        r_b_in1;

  logic signed [INT_W-1:0]  w_int;
  logic [MAN_W-1:0]         w_man;
  logic [DATA_W-1:0]        w_pow;
  int                       w_i;

  // Floor of x (arithmetic shift) and the implicit-one mantissa 1+F
  assign w_int = INT_W'($signed(in_0) >>> FRAC_W);
  assign w_man = {1'b1, in_0[FRAC_W-1:0]};

  // Saturating barrel shift of the mantissa by the integer exponent
  always_comb begin
    w_pow = '0;
    w_i   = int'(r_a_int);
    if (w_i > MAX_LSH) begin
      w_pow = SAT_VAL;
    end else if (w_i >= 0) begin
      w_pow = DATA_W'(r_a_man) << w_i;
    end else if (w_i >= MIN_RSH) begin
      w_pow = DATA_W'(r_a_man >> (-w_i));
    end
  end

  // Stage A: valid shifts on every enabled edge, data loads only with a valid input
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_valid <= 1'b0;
      r_a_int   <= '0;
      r_a_man   <= '0;
      r_a_in0   <= '0;
      r_a_in1   <= '0;
    end else if (en) begin
      r_a_valid <= valid_in;
      if (valid_in) begin
        r_a_int <= w_int;
        r_a_man <= w_man;
        r_a_in0 <= in_0;
        r_a_in1 <= in_1;
      end
    end
  end

  // Stage B: results hold their last valid value across bubbles and stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      r_b_valid <= 1'b0;
      r_b_pow   <= '0;
      r_b_in0   <= '0;
      r_b_in1   <= '0;
    end else if (en) begin
      r_b_valid <= r_a_valid;
      if (r_a_valid) begin
        r_b_pow <= w_pow;
        r_b_in0 <= r_a_in0;
        r_b_in1 <= r_a_in1;
      end
    end
  end

  assign valid_out   = r_b_valid;
  assign pow_out     = r_b_pow;
  assign in_0_bypass = r_b_in0;
  assign in_1_bypass = r_b_in1;

endmodule

// File: tb/tb_stage3_pow2_approx.sv
// Bench for stage3_pow2_approx: directed and random stimulus against a real-arithmetic pow2 model.
module tb_stage3_pow2_approx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        valid_in = 1'b0;
  logic [15:0] in_0 = '0;
  logic [15:0] in_1 = '0;
  logic        valid_out;
  logic [15:0] pow_out;
  logic [15:0] in_0_bypass;
  logic [15:0] in_1_bypass;

  stage3_pow2_approx #(.DATA_W(16), .FRAC_W(10)) dut (
    .clk(clk), .rst(rst), .en(en), .valid_in(valid_in),
    .in_0(in_0), .in_1(in_1),
    .valid_out(valid_out), .pow_out(pow_out),
    .in_0_bypass(in_0_bypass), .in_1_bypass(in_1_bypass)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          edge_n;
    logic [15:0] p;
    logic [15:0] a;
    logic [15:0] b;
  } item_t;

  item_t       q[$];
  int          n_edge = 0;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic        exp_v = 1'b0;
  logic [15:0] exp_p = '0;
  logic [15:0] exp_a = '0;
  logic [15:0] exp_b = '0;

  // 2^x for x in Q6.10, computed as (1+F)*2^I in real arithmetic, truncated, clamped to 0x7FFF
  function automatic logic [15:0] ref_pow(input logic [15:0] x);
    int  xi;
    int  f;
    int  ip;
    real v;
    xi = int'($signed(x));
    f  = xi & 1023;
    ip = (xi - f) / 1024;
    v  = (1024.0 + real'(f)) * (2.0 ** ip);
    if (v >= 32767.0) return 16'h7FFF;
    return 16'(int'($floor(v)));
  endfunction

  // One clock: drive inputs, advance the model, set exp_* for the cycle after the edge
  task automatic step(input logic e, input logic v, input logic [15:0] a, input logic [15:0] b);
    item_t it;
    @(negedge clk);
    en = e; valid_in = v; in_0 = a; in_1 = b;
    @(posedge clk);
    #1;
    cyc++;
    if (e) begin
      n_edge++;
      if (v) begin
        it.edge_n = n_edge; it.p = ref_pow(a); it.a = a; it.b = b;
        q.push_back(it);
      end
      if (q.size() > 0 && q[0].edge_n == n_edge - 1) begin
        it = q.pop_front();
        exp_v = 1'b1; exp_p = it.p; exp_a = it.a; exp_b = it.b;
      end else begin
        exp_v = 1'b0;
      end
    end
  endtask

  task automatic apply_reset(input logic e);
    @(negedge clk);
    rst = 1'b1; en = e; valid_in = 1'b1; in_0 = 16'(($urandom)); in_1 = 16'($urandom);
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
    q.delete();
    exp_v = 1'b0; exp_p = '0; exp_a = '0; exp_b = '0;
  endtask

  task automatic test_reset();
    apply_reset(1'b0);
    total++;
    if ({valid_out, pow_out, in_0_bypass, in_1_bypass} !== 49'h0) begin
      bad++;
      $display("FAIL reset_zero got v=%b p=%h a=%h b=%h want all 0", valid_out, pow_out, in_0_bypass, in_1_bypass);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 16'($urandom), 16'($urandom));
      total++;
      if ({valid_out, pow_out, in_0_bypass, in_1_bypass} !== {exp_v, exp_p, exp_a, exp_b}) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d got v=%b p=%h want v=%b p=%h", cyc, valid_out, pow_out, exp_v, exp_p);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] vals[5];
    vals = '{16'h0000, 16'h0400, 16'hFC00, 16'h0200, 16'h1000};
    for (int i = 0; i < 7; i++) begin
      if (i < 5) step(1'b1, 1'b1, vals[i], 16'hA000 + 16'(i));
      else       step(1'b1, 1'b0, 16'h0, 16'h0);
      total++;
      if ({valid_out, pow_out, in_0_bypass, in_1_bypass} !== {exp_v, exp_p, exp_a, exp_b}) begin
        bad++;
        $display("FAIL back_to_back cyc=%0d got v=%b p=%h a=%h b=%h want v=%b p=%h a=%h b=%h",
                 cyc, valid_out, pow_out, in_0_bypass, in_1_bypass, exp_v, exp_p, exp_a, exp_b);
      end
    end
  endtask

  task automatic test_boundary();
    logic [15:0] vals[6];
    vals = '{16'h1400, 16'h7FFF, 16'h13FF, 16'hD800, 16'hD400, 16'h8000};
    for (int i = 0; i < 8; i++) begin
      if (i < 6) step(1'b1, 1'b1, vals[i], 16'(~i));
      else       step(1'b1, 1'b0, 16'h0, 16'h0);
      total++;
      if ({valid_out, pow_out, in_0_bypass, in_1_bypass} !== {exp_v, exp_p, exp_a, exp_b}) begin
        bad++;
        $display("FAIL boundary cyc=%0d got v=%b p=%h a=%h want v=%b p=%h a=%h",
                 cyc, valid_out, pow_out, in_0_bypass, exp_v, exp_p, exp_a);
      end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 10; i++) begin
      if (i < 2)       step(1'b1, 1'b1, 16'h0800 + 16'(i * 16'h0155), 16'h5000 + 16'(i));
      else if (i < 6)  step(1'b0, 1'b1, 16'($urandom), 16'($urandom));
      else if (i == 6) step(1'b1, 1'b1, 16'hF9AB, 16'h5002);
      else             step(1'b1, 1'b0, 16'h0, 16'h0);
      total++;
      if ({valid_out, pow_out, in_0_bypass, in_1_bypass} !== {exp_v, exp_p, exp_a, exp_b}) begin
        bad++;
        $display("FAIL stall cyc=%0d got v=%b p=%h b=%h want v=%b p=%h b=%h",
                 cyc, valid_out, pow_out, in_1_bypass, exp_v, exp_p, exp_b);
      end
    end
  endtask

  task automatic test_bubbles();
    logic pat[5];
    pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      step(1'b1, pat[i], 16'h0300 + 16'(i * 16'h0111), 16'h7700 + 16'(i));
      total++;
      if ({valid_out, pow_out, in_0_bypass, in_1_bypass} !== {exp_v, exp_p, exp_a, exp_b}) begin
        bad++;
        $display("FAIL bubbles cyc=%0d got v=%b p=%h want v=%b p=%h", cyc, valid_out, pow_out, exp_v, exp_p);
      end
    end
  endtask

  task automatic test_random();
    logic        e;
    logic        v;
    logic [15:0] a;
    int          ip;
    for (int i = 0; i < 300; i++) begin
      e = ($urandom % 4) != 0;
      v = ($urandom % 3) != 0;
      if ($urandom % 2 == 0) begin
        a = 16'($urandom);
      end else begin
        ip = int'($urandom_range(0, 18)) - 12;
        a = 16'(ip * 1024 + int'($urandom_range(0, 1023)));
      end
      step(e, v, a, 16'($urandom));
      total++;
      if ({valid_out, pow_out, in_0_bypass, in_1_bypass} !== {exp_v, exp_p, exp_a, exp_b}) begin
        bad++;
        $display("FAIL random cyc=%0d got v=%b p=%h a=%h b=%h want v=%b p=%h a=%h b=%h",
                 cyc, valid_out, pow_out, in_0_bypass, in_1_bypass, exp_v, exp_p, exp_a, exp_b);
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 16'h0, 16'h0);
      total++;
      if ({valid_out, pow_out, in_0_bypass, in_1_bypass} !== {exp_v, exp_p, exp_a, exp_b}) begin
        bad++;
        $display("FAIL random_drain cyc=%0d got v=%b p=%h want v=%b p=%h", cyc, valid_out, pow_out, exp_v, exp_p);
      end
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL random_pending got %0d items left want 0", q.size());
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b1, 16'h0A55, 16'h1234);
    step(1'b1, 1'b1, 16'h0C00, 16'h4321);
    apply_reset(1'b1);
    total++;
    if ({valid_out, pow_out, in_0_bypass, in_1_bypass} !== 49'h0) begin
      bad++;
      $display("FAIL reset_mid got v=%b p=%h a=%h b=%h want all 0", valid_out, pow_out, in_0_bypass, in_1_bypass);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 16'h0, 16'h0);
      total++;
      if ({valid_out, pow_out, in_0_bypass, in_1_bypass} !== {exp_v, exp_p, exp_a, exp_b}) begin
        bad++;
        $display("FAIL reset_mid_after cyc=%0d got v=%b p=%h want v=%b p=%h", cyc, valid_out, pow_out, exp_v, exp_p);
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_boundary();
    test_stall();
    test_bubbles();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
